// File: rtl/memfifo_emu_pkg.sv
// Shared definitions for the memory-FIFO emulator and its read-side checker.
// Holds the FSM state type, data-pattern field offsets and the word former.
package memfifo_emu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int WPP_DEFAULT = 2;
    localparam int TAG_LSB     = 16;
    localparam int IDX_LSB     = 0;

    // Checker and responder both build words here so the pattern
    // can never drift between the two ends.
    function automatic logic [31:0] form_word(
        input logic [15:0] tag,
        input logic [15:0] idx
    );
        logic [31:0] w;
        w = '0;
        w[TAG_LSB +: 16] = tag;
        w[IDX_LSB +: 16] = idx;
        return w;
    endfunction

endpackage

// File: rtl/memfifo_data_responder.sv
// Emulates the memory-FIFO side of a Data_Request: latches a request, waits
// READY_DELAY clocks, then returns one patterned word per memfifo_re pulse.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               Data_Request pulse; packet_no, tag sampled with it
//   memfifo_re          one-clock read enable per word
//   memfifo_data_ready  words available
//   memfifo_data        registered read word, held when not valid
//   memfifo_valid       memfifo_data valid this cycle
//   words_left          words remaining in the current request
//   done                one-cycle pulse with the last valid word
//   err_underrun        sticky: read with no word available
//   err_restart         sticky: start while busy
module memfifo_data_responder
    import memfifo_emu_pkg::*;
#(
    parameter int READY_DELAY      = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int WORDS_PER_PACKET = WPP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           packet_no,
    input  logic [15:0]           tag,
    input  logic                  memfifo_re,
    output logic                  memfifo_data_ready,
    output logic [DATA_WIDTH-1:0] memfifo_data,
    output logic                  memfifo_valid,
    output logic [16:0]           words_left,
    output logic                  done,
    output logic                  err_underrun,
    output logic                  err_restart
);

    state_t      state;
    logic [7:0]  dly_cnt;
    logic [15:0] tag_q;
    logic [15:0] word_idx;
    logic [16:0] req_words;
    logic        accept;
    logic        last;

    assign req_words = {1'b0, packet_no} * 17'(WORDS_PER_PACKET);
    assign accept    = memfifo_re && (state == READY)
                       && (words_left != 17'd0);
    assign last      = accept && (words_left == 17'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            dly_cnt            <= '0;
            tag_q              <= '0;
            word_idx           <= '0;
            words_left         <= '0;
            memfifo_data_ready <= 1'b0;
            memfifo_data       <= '0;
            memfifo_valid      <= 1'b0;
            done               <= 1'b0;
            err_underrun       <= 1'b0;
            err_restart        <= 1'b0;
        end else begin
            done          <= 1'b0;
            memfifo_valid <= accept;

            if (accept) begin
                memfifo_data <= DATA_WIDTH'(form_word(tag_q, word_idx));
                word_idx     <= word_idx + 16'd1;
                words_left   <= words_left - 17'd1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        tag_q        <= tag;
                        words_left   <= req_words;
                        word_idx     <= '0;
                        dly_cnt      <= '0;
                        err_underrun <= 1'b0;
                        err_restart  <= 1'b0;
                        if (req_words == 17'd0)
                            done  <= 1'b1;
                        else
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dly_cnt == 8'(READY_DELAY - 1))
                        state   <= READY;
                    else
                        dly_cnt <= dly_cnt + 8'd1;
                end
                READY: begin
                    // data_ready trails the state by one clock, giving
                    // READY_DELAY+1 clocks from start.
                    if (last) begin
                        state              <= IDLE;
                        memfifo_data_ready <= 1'b0;
                        done               <= 1'b1;
                    end else begin
                        memfifo_data_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start && (state != IDLE))
                err_restart <= 1'b1;

            // Placed after the start-clear so a same-cycle re still flags.
            if (memfifo_re && !accept)
                err_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memfifo_data_responder.sv
// Directed self-checking bench for memfifo_data_responder.
// Inputs driven and outputs sampled on the falling edge.
module tb_memfifo_data_responder;
    import memfifo_emu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] packet_no = '0;
    logic [15:0] tag = '0;
    logic        memfifo_re = 1'b0;
    logic        memfifo_data_ready;
    logic [31:0] memfifo_data;
    logic        memfifo_valid;
    logic [16:0] words_left;
    logic        done;
    logic        err_underrun;
    logic        err_restart;

    int errors = 0;
    int checks = 0;

    memfifo_data_responder #(
        .READY_DELAY(16),
        .DATA_WIDTH(32),
        .WORDS_PER_PACKET(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .packet_no(packet_no),
        .tag(tag),
        .memfifo_re(memfifo_re),
        .memfifo_data_ready(memfifo_data_ready),
        .memfifo_data(memfifo_data),
        .memfifo_valid(memfifo_valid),
        .words_left(words_left),
        .done(done),
        .err_underrun(err_underrun),
        .err_restart(err_restart)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic req(input logic [15:0] pn, input logic [15:0] tg);
        start     = 1'b1;
        packet_no = pn;
        tag       = tg;
        tick();
        start     = 1'b0;
    endtask

    // Ticks until data_ready, returns clocks counted after the start edge.
    task automatic wait_ready(output int n);
        n = 0;
        while (!memfifo_data_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic read1();
        memfifo_re = 1'b1;
        tick();
        memfifo_re = 1'b0;
    endtask

    initial begin
        int n;
        int vcnt;
        int bad;
        int dones;
        logic [63:0] outs;

        // Reset state
        @(negedge clk);
        tick();
        outs = {memfifo_data_ready, memfifo_data, memfifo_valid,
                words_left, done, err_underrun, err_restart};
        chk("reset_outputs", outs, 64'd0);
        rst = 1'b0;
        tick();

        // Main request: 3 packets, tag A5A5
        req(16'd3, 16'hA5A5);
        chk("words_left_init", 64'(words_left), 64'd6);
        wait_ready(n);
        chk("ready_latency", 64'(n), 64'd17);
        for (int k = 0; k < 6; k++) begin
            read1();
            chk("valid", 64'(memfifo_valid), 64'd1);
            chk("data", 64'(memfifo_data), 64'(32'hA5A50000 + k));
            chk("words_left", 64'(words_left), 64'(5 - k));
            chk("done", 64'(done), (k == 5) ? 64'd1 : 64'd0);
            chk("ready_level", 64'(memfifo_data_ready),
                (k == 5) ? 64'd0 : 64'd1);
            for (int s = 0; s < 8; s++) tick();
        end
        chk("no_err", 64'({err_underrun, err_restart}), 64'd0);
        chk("data_hold", 64'(memfifo_data), 64'h0000_0000_A5A5_0005);

        // Zero-packet request
        req(16'd0, 16'h1111);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_words", 64'(words_left), 64'd0);
        n = 0;
        for (int s = 0; s < 25; s++) begin
            tick();
            if (memfifo_data_ready || done) n++;
        end
        chk("zero_no_ready", 64'(n), 64'd0);

        // Underrun in WAIT, restart in READY
        req(16'd1, 16'h1234);
        read1();
        chk("wait_re_valid", 64'(memfifo_valid), 64'd0);
        chk("wait_re_err", 64'(err_underrun), 64'd1);
        chk("wait_re_words", 64'(words_left), 64'd2);
        wait_ready(n);
        chk("ready_seen", 64'(memfifo_data_ready), 64'd1);
        start = 1'b1; packet_no = 16'd7; tag = 16'hFFFF;
        tick();
        start = 1'b0;
        chk("restart_err", 64'(err_restart), 64'd1);
        chk("restart_words", 64'(words_left), 64'd2);
        read1();
        chk("rs_data0", 64'(memfifo_data), 64'h1234_0000);
        read1();
        chk("rs_data1", 64'(memfifo_data), 64'h1234_0001);
        chk("rs_done", 64'(done), 64'd1);

        // Accepted start clears errors; re after completion underruns
        req(16'd1, 16'h0BEE);
        chk("clear_errs", 64'({err_underrun, err_restart}), 64'd0);
        wait_ready(n);
        read1();
        read1();
        chk("b_done", 64'(done), 64'd1);
        read1();
        chk("post_valid", 64'(memfifo_valid), 64'd0);
        chk("post_err", 64'(err_underrun), 64'd1);
        chk("post_words", 64'(words_left), 64'd0);
        chk("post_hold", 64'(memfifo_data), 64'h0BEE_0001);

        // Same-cycle start and re in IDLE
        start = 1'b1; packet_no = 16'd1; tag = 16'h2222;
        memfifo_re = 1'b1;
        tick();
        start = 1'b0; memfifo_re = 1'b0;
        chk("same_cyc_err", 64'(err_underrun), 64'd1);
        chk("same_cyc_words", 64'(words_left), 64'd2);
        wait_ready(n);
        read1();
        read1();

        // Reset mid-request
        req(16'd2, 16'h5A5A);
        wait_ready(n);
        read1();
        read1();
        chk("pre_rst_words", 64'(words_left), 64'd2);
        rst = 1'b1;
        #1;
        outs = {memfifo_data_ready, memfifo_data, memfifo_valid,
                words_left, done, err_underrun, err_restart};
        chk("async_rst", outs, 64'd0);
        tick();
        chk("rst_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();
        req(16'd1, 16'h7777);
        wait_ready(n);
        read1();
        chk("after_rst_data", 64'(memfifo_data), 64'h7777_0000);
        read1();

        // Large request, back-to-back drain with index wrap
        req(16'h8000, 16'hC0DE);
        chk("big_words", 64'(words_left), 64'h10000);
        wait_ready(n);
        vcnt = 0; bad = 0; dones = 0;
        memfifo_re = 1'b1;
        for (int s = 0; s < 70000; s++) begin
            tick();
            if (words_left == 17'd0) memfifo_re = 1'b0;
            if (!memfifo_valid) bad++;
            else if (memfifo_data != form_word(16'hC0DE, vcnt[15:0])) bad++;
            if (memfifo_valid) vcnt++;
            if (done) begin
                dones++;
                break;
            end
        end
        memfifo_re = 1'b0;
        chk("big_valids", 64'(vcnt), 64'd65536);
        chk("big_bad", 64'(bad), 64'd0);
        chk("big_done", 64'(dones), 64'd1);
        chk("big_last", 64'(memfifo_data), 64'hC0DE_FFFF);
        chk("big_noerr", 64'(err_underrun), 64'd0);
        tick();
        chk("big_ready_low", 64'(memfifo_data_ready), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
